// File: rtl/fuzzy_t2_rule_engine.sv
// Interval type-2 fuzzy rule evaluator: min t-norm over N_TERMS^2 rules, midpoint-weighted centroid
// accumulation, serial restoring divide. Optional macro FUZZY_HOLD_LAST_EN keeps the last output when no rule fires.
module fuzzy_t2_rule_engine #(
  parameter int W            = 8,
  parameter int N_TERMS      = 3,
  parameter int ZERO_OUT_VAL = 128,
  localparam int NUM_RULES   = N_TERMS * N_TERMS,
  localparam int RW          = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
  localparam int TW          = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  localparam int CW          = (W > 1) ? $clog2(W) : 1,
  localparam int NUM_W       = 2 * W + RW,
  localparam int DEN_W       = W + RW
) (
  input  logic                   clk_0,
  input  logic                   Srst,
  input  logic                   start,
  input  logic [N_TERMS*W-1:0]   mu_up_a,
  input  logic [N_TERMS*W-1:0]   mu_low_a,
  input  logic [N_TERMS*W-1:0]   mu_up_b,
  input  logic [N_TERMS*W-1:0]   mu_low_b,
  input  logic                   cfg_we,
  input  logic [RW-1:0]          cfg_addr,
  input  logic [W-1:0]           cfg_data,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           saida_defuzzy,
  output logic [RW-1:0]          sequencia_regras,
  output logic [NUM_RULES-1:0]   fou_ativo
);

  typedef enum logic [1:0] {S_IDLE, S_RULE, S_DIV, S_DONE} state_t;

  localparam logic [RW:0] ADDR_LIM = (RW + 1)'(NUM_RULES);

  function automatic logic [W-1:0] min_g(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y) ? x : y;
  endfunction

  // Midpoint of the firing interval, computed on a W+1-bit sum and truncated.
  function automatic logic [W-1:0] mid_g(input logic [W-1:0] u, input logic [W-1:0] l);
    logic [W:0] s;
    s = {1'b0, u} + {1'b0, l};
    return s[W:1];
  endfunction

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W-1:0]         saida_q, saida_d;
  logic [RW-1:0]        rule_q, rule_d;
  logic [TW-1:0]        ta_q, ta_d;
  logic [TW-1:0]        tb_q, tb_d;
  logic [NUM_RULES-1:0] fou_q, fou_d;
  logic [NUM_W-1:0]     num_q, num_d;
  logic [DEN_W-1:0]     den_q, den_d;
  logic [NUM_W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [W-1:0]         cent_q [NUM_RULES];
  logic [W-1:0]         cent_d [NUM_RULES];

  logic [W-1:0]         up_a_s  [N_TERMS];
  logic [W-1:0]         low_a_s [N_TERMS];
  logic [W-1:0]         up_b_s  [N_TERMS];
  logic [W-1:0]         low_b_s [N_TERMS];
  logic                 load_snap;

  logic [W-1:0]         up_g, lo_g, f_g;
  logic [2*W-1:0]       prod_g;
  logic                 ge_div;

  always_comb begin
    up_g   = min_g(up_a_s[ta_q], up_b_s[tb_q]);
    lo_g   = min_g(low_a_s[ta_q], low_b_s[tb_q]);
    f_g    = mid_g(up_g, lo_g);
    prod_g = {{W{1'b0}}, f_g} * {{W{1'b0}}, cent_q[rule_q]};
    ge_div = (num_q >= dvs_q);
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    saida_d   = saida_q;
    rule_d    = rule_q;
    ta_d      = ta_q;
    tb_d      = tb_q;
    fou_d     = fou_q;
    num_d     = num_q;
    den_d     = den_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    bit_d     = bit_q;
    cent_d    = cent_q;
    load_snap = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A table write coinciding with start lands first, so the run sees the new centroid.
        if (cfg_we && ({1'b0, cfg_addr} < ADDR_LIM)) cent_d[cfg_addr] = cfg_data;
        if (start) begin
          state_d   = S_RULE;
          busy_d    = 1'b1;
          num_d     = '0;
          den_d     = '0;
          fou_d     = '0;
          rule_d    = '0;
          ta_d      = '0;
          tb_d      = '0;
          load_snap = 1'b1;
        end
      end
      S_RULE: begin
        num_d         = num_q + NUM_W'(prod_g);
        den_d         = den_q + DEN_W'(f_g);
        fou_d[rule_q] = (up_g != '0);
        if (rule_q == RW'(NUM_RULES - 1)) begin
          state_d = S_DIV;
          rule_d  = '0;
          ta_d    = '0;
          tb_d    = '0;
          dvs_d   = NUM_W'(den_d) << (W - 1);
          quo_d   = '0;
          bit_d   = CW'(W - 1);
        end else begin
          rule_d = rule_q + 1'b1;
          if (tb_q == TW'(N_TERMS - 1)) begin
            tb_d = '0;
            ta_d = ta_q + 1'b1;
          end else begin
            tb_d = tb_q + 1'b1;
          end
        end
      end
      S_DIV: begin
        // Divisor starts at den<<(W-1) and walks right; the quotient fits W bits by construction.
        if (ge_div) num_d = num_q - dvs_q;
        quo_d = {quo_q[W-2:0], ge_div};
        dvs_d = dvs_q >> 1;
        if (bit_q == '0) state_d = S_DONE;
        else             bit_d   = bit_q - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef FUZZY_HOLD_LAST_EN
        if (den_q != '0) saida_d = quo_q;
`else
        saida_d = (den_q == '0) ? W'(ZERO_OUT_VAL) : quo_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      saida_q <= '0;
      rule_q  <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      fou_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      for (int r = 0; r < NUM_RULES; r++) cent_q[r] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      saida_q <= saida_d;
      rule_q  <= rule_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      fou_q   <= fou_d;
      num_q   <= num_d;
      den_q   <= den_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      for (int r = 0; r < NUM_RULES; r++) cent_q[r] <= cent_d[r];
    end
  end

  // Input snapshot at the start edge; later input changes cannot disturb a run.
  always_ff @(posedge clk_0) begin
    if (load_snap) begin
      for (int k = 0; k < N_TERMS; k++) begin
        up_a_s[k]  <= mu_up_a[k*W +: W];
        low_a_s[k] <= mu_low_a[k*W +: W];
        up_b_s[k]  <= mu_up_b[k*W +: W];
        low_b_s[k] <= mu_low_b[k*W +: W];
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign saida_defuzzy    = saida_q;
  assign sequencia_regras = rule_q;
  assign fou_ativo        = fou_q;

endmodule
